// File: rtl/alu_clmul.sv
// Iterative carry-less multiplier (clmul / clmulh / clmulr), BPC multiplier bits per cycle.
// Optional macro ALU_CLMUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module alu_clmul #(
  parameter int RV       = 64,
  parameter int BPC      = 4,
  parameter int NHART    = 1,
  parameter int LNHART   = 0,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  localparam int HW      = (LNHART > 0) ? LNHART : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                ready,
  input  logic [1:0]          control,
  input  logic [LNCOMMIT-1:0] rd,
  input  logic [HW-1:0]       hart,
  input  logic                rv32,
  input  logic [RV-1:0]       r1,
  input  logic [RV-1:0]       r2,
  input  logic [NCOMMIT-1:0]  commit_kill,
  output logic [RV-1:0]       result,
  output logic [LNCOMMIT-1:0] res_rd,
  output logic [NHART-1:0]    res_makes_rd,
  output logic                dbg_state_o
);

  localparam int AW = 2 * RV;
  localparam int CW = $clog2(RV / BPC) + 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  // Handshake: an op transfers on a rising edge where enable && ready, unless its slot is
  // being killed in that same cycle (then it is silently dropped). ready is high only in IDLE.

  state_e              state_q, state_d;
  logic [1:0]          op_q;
  logic [LNCOMMIT-1:0] rd_q;
  logic [HW-1:0]       hart_q;
  logic                w32_q;
  logic [AW-1:0]       mcand_q;
  logic [RV-1:0]       mplier_q;
  logic [AW-1:0]       acc_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       nlast_q;

  logic [RV-1:0]       result_q, result_d;
  logic [LNCOMMIT-1:0] res_rd_q;
  logic [NHART-1:0]    res_makes_rd_q;

  logic [AW-1:0]       acc_step;
  logic [AW-1:0]       mcand_nxt;
  logic [RV-1:0]       mplier_nxt;
  logic                last_step;
  logic                kill_run;
  logic                kill_acc;
  logic                accept;
  logic                complete;

  assign kill_acc = (hart == '0) && commit_kill[rd];
  assign kill_run = (hart_q == '0) && commit_kill[rd_q];
  assign accept   = enable && ready && !kill_acc;

  // One step: fold BPC partial products; the multiplicand register already carries cnt*BPC.
  always_comb begin
    acc_step = acc_q;
    for (int i = 0; i < BPC; i++) begin
      if (mplier_q[i]) acc_step = acc_step ^ (mcand_q << i);
    end
    mcand_nxt  = mcand_q << BPC;
    mplier_nxt = mplier_q >> BPC;
`ifdef ALU_CLMUL_EARLY_OUT_EN
    last_step  = (cnt_q == nlast_q) || (mplier_nxt == '0);
`else
    last_step  = (cnt_q == nlast_q);
`endif
  end

  always_comb begin
    logic [31:0]   v32;
    logic [RV-1:0] vw;
    case (op_q)
      2'd1: begin
        vw  = acc_step[AW-1:RV];
        v32 = acc_step[63:32];
      end
      2'd2: begin
        vw  = acc_step[AW-2:RV-1];
        v32 = acc_step[62:31];
      end
      default: begin
        vw  = acc_step[RV-1:0];
        v32 = acc_step[31:0];
      end
    endcase
    result_d = w32_q ? RV'($signed(v32)) : vw;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (kill_run || last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready       = (state_q == S_IDLE);
    complete    = (state_q == S_RUN) && last_step && !kill_run;
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      rd_q     <= '0;
      hart_q   <= '0;
      w32_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      nlast_q  <= '0;
    end else if (accept) begin
      op_q     <= control;
      rd_q     <= rd;
      hart_q   <= hart;
      w32_q    <= rv32;
      mcand_q  <= rv32 ? AW'(r1[31:0]) : AW'(r1);
      mplier_q <= rv32 ? RV'(r2[31:0]) : r2;
      acc_q    <= '0;
      cnt_q    <= '0;
      nlast_q  <= rv32 ? CW'(32 / BPC - 1) : CW'(RV / BPC - 1);
    end else if (state_q == S_RUN) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_nxt;
      mplier_q <= mplier_nxt;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // Write-back registers: strobe for exactly one cycle, value and slot held until next completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q       <= '0;
      res_rd_q       <= '0;
      res_makes_rd_q <= '0;
    end else begin
      res_makes_rd_q <= complete ? (NHART'(1) << hart_q) : '0;
      if (complete) begin
        result_q <= result_d;
        res_rd_q <= rd_q;
      end
    end
  end

  assign result       = result_q;
  assign res_rd       = res_rd_q;
  assign res_makes_rd = res_makes_rd_q;

endmodule

// File: tb/tb_alu_clmul.sv
// Directed bench for alu_clmul (RV=64, BPC=4): results, latency, kill, reset, back-to-back issue.
module tb_alu_clmul;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        ready;
  logic [1:0]  control;
  logic [4:0]  rd;
  logic [0:0]  hart;
  logic        rv32;
  logic [63:0] r1;
  logic [63:0] r2;
  logic [31:0] commit_kill;
  logic [63:0] result;
  logic [4:0]  res_rd;
  logic [0:0]  res_makes_rd;
  logic        dbg_state;

  int n_cmp;
  int n_bad;

  alu_clmul dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .ready        (ready),
    .control      (control),
    .rd           (rd),
    .hart         (hart),
    .rv32         (rv32),
    .r1           (r1),
    .r2           (r2),
    .commit_kill  (commit_kill),
    .result       (result),
    .res_rd       (res_rd),
    .res_makes_rd (res_makes_rd),
    .dbg_state_o  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected accept-to-strobe latency in cycles.
  function automatic int exp_lat(input logic [63:0] b, input logic m32);
    int n;
    int steps;
    logic [63:0] v;
    n = m32 ? 8 : 16;
    v = m32 ? {32'h0, b[31:0]} : b;
    steps = n;
`ifdef ALU_CLMUL_EARLY_OUT_EN
    steps = 1;
    for (int k = 1; k < n; k++) begin
      if ((v >> (4 * k)) != 64'h0) steps = k + 1;
    end
`endif
    return steps + 1;
  endfunction

  // driver: present an op at cycle 0; returns at the negedge of cycle 1 with enable dropped
  task automatic drive_issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic m32, input logic [4:0] slot);
    @(negedge clk);
    control = op; r1 = a; r2 = b; rv32 = m32; rd = slot; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  // driver: step negedges until the strobe shows, bounded; counts cycles with ready high
  task automatic wait_strobe(input int start_cyc, output int cyc, output int ready_high);
    cyc = start_cyc;
    ready_high = 0;
    while (res_makes_rd == 1'b0 && cyc <= 40) begin
      if (ready) ready_high++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; enable = 1'b0; control = 2'd0; rd = 5'd0; hart = 1'b0; rv32 = 1'b0;
    r1 = 64'h0; r2 = 64'h0; commit_kill = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", ready); end
    n_cmp++; if (res_makes_rd !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %b want 0", res_makes_rd); end
    n_cmp++; if (result !== 64'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (res_rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", res_rd); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL reset_state got %b want 0", dbg_state); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops;
    logic [1:0]  v_op  [13];
    logic [63:0] v_a   [13];
    logic [63:0] v_b   [13];
    logic        v_m32 [13];
    logic [63:0] v_exp [13];
    int cyc;
    int rh;
    v_op[0]  = 2'd0; v_a[0]  = 64'h3;                   v_b[0]  = 64'h3;                   v_m32[0]  = 1'b0; v_exp[0]  = 64'h5;
    v_op[1]  = 2'd1; v_a[1]  = 64'h8000_0000_0000_0000; v_b[1]  = 64'h8000_0000_0000_0000; v_m32[1]  = 1'b0; v_exp[1]  = 64'h4000_0000_0000_0000;
    v_op[2]  = 2'd2; v_a[2]  = 64'h8000_0000_0000_0000; v_b[2]  = 64'h8000_0000_0000_0000; v_m32[2]  = 1'b0; v_exp[2]  = 64'h8000_0000_0000_0000;
    v_op[3]  = 2'd0; v_a[3]  = 64'h8000_0000_0000_0000; v_b[3]  = 64'h8000_0000_0000_0000; v_m32[3]  = 1'b0; v_exp[3]  = 64'h0;
    v_op[4]  = 2'd0; v_a[4]  = 64'hDEAD_0000_8000_0001; v_b[4]  = 64'h1234_0000_0000_0003; v_m32[4]  = 1'b1; v_exp[4]  = 64'hFFFF_FFFF_8000_0003;
    v_op[5]  = 2'd1; v_a[5]  = 64'h8000_0000;           v_b[5]  = 64'h8000_0000;           v_m32[5]  = 1'b1; v_exp[5]  = 64'h4000_0000;
    v_op[6]  = 2'd2; v_a[6]  = 64'h8000_0000;           v_b[6]  = 64'h8000_0000;           v_m32[6]  = 1'b1; v_exp[6]  = 64'hFFFF_FFFF_8000_0000;
    v_op[7]  = 2'd3; v_a[7]  = 64'h3;                   v_b[7]  = 64'h3;                   v_m32[7]  = 1'b0; v_exp[7]  = 64'h5;
    v_op[8]  = 2'd1; v_a[8]  = 64'hFFFF_FFFF_FFFF_FFFF; v_b[8]  = 64'h2;                   v_m32[8]  = 1'b0; v_exp[8]  = 64'h1;
    v_op[9]  = 2'd0; v_a[9]  = 64'h0F;                  v_b[9]  = 64'h11;                  v_m32[9]  = 1'b0; v_exp[9]  = 64'hFF;
    v_op[10] = 2'd0; v_a[10] = 64'h5;                   v_b[10] = 64'h0;                   v_m32[10] = 1'b0; v_exp[10] = 64'h0;
    v_op[11] = 2'd2; v_a[11] = 64'hFFFF_FFFF_FFFF_FFFF; v_b[11] = 64'hFFFF_FFFF_FFFF_FFFF; v_m32[11] = 1'b0; v_exp[11] = 64'hAAAA_AAAA_AAAA_AAAA;
    v_op[12] = 2'd0; v_a[12] = 64'hFFFF_FFFF;           v_b[12] = 64'hFFFF_FFFF;           v_m32[12] = 1'b1; v_exp[12] = 64'h5555_5555;
    for (int i = 0; i < 13; i++) begin
      drive_issue(v_op[i], v_a[i], v_b[i], v_m32[i], 5'(i + 1));
      n_cmp++; if (dbg_state !== 1'b1) begin n_bad++; $display("FAIL op%0d_state got %b want 1", i, dbg_state); end
      wait_strobe(1, cyc, rh);
      n_cmp++; if (cyc !== exp_lat(v_b[i], v_m32[i])) begin n_bad++; $display("FAIL op%0d_latency got %0d want %0d", i, cyc, exp_lat(v_b[i], v_m32[i])); end
      n_cmp++; if (rh !== 0) begin n_bad++; $display("FAIL op%0d_busy_ready got %0d cycles high want 0", i, rh); end
      n_cmp++; if (result !== v_exp[i]) begin n_bad++; $display("FAIL op%0d_result got %h want %h", i, result, v_exp[i]); end
      n_cmp++; if (res_rd !== 5'(i + 1)) begin n_bad++; $display("FAIL op%0d_res_rd got %0d want %0d", i, res_rd, i + 1); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL op%0d_ready_done got %b want 1", i, ready); end
      @(negedge clk);
      n_cmp++; if (res_makes_rd !== 1'b0) begin n_bad++; $display("FAIL op%0d_strobe_width got %b want 0", i, res_makes_rd); end
    end
  endtask

  task automatic test_kill;
    int cyc;
    int rh;
    int seen;
    // kill mid-run at cycle 6
    drive_issue(2'd0, 64'h3, 64'h8000_0000_0000_0000, 1'b0, 5'd5);
    repeat (5) @(negedge clk);
    commit_kill[5] = 1'b1;
    @(negedge clk);
    commit_kill[5] = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL kill_mid_ready got %b want 1", ready); end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_makes_rd !== 1'b0) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL kill_mid_strobe got %0d strobes want 0", seen); end
    // kill in the final run cycle
    drive_issue(2'd0, 64'h3, 64'h8000_0000_0000_0000, 1'b0, 5'd6);
    repeat (15) @(negedge clk);
    commit_kill[6] = 1'b1;
    @(negedge clk);
    commit_kill[6] = 1'b0;
    n_cmp++; if (res_makes_rd !== 1'b0) begin n_bad++; $display("FAIL kill_last_strobe got %b want 0", res_makes_rd); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL kill_last_ready got %b want 1", ready); end
    // kill on the issue cycle drops the op
    @(negedge clk);
    control = 2'd0; r1 = 64'h3; r2 = 64'h3; rv32 = 1'b0; rd = 5'd4; enable = 1'b1; commit_kill[4] = 1'b1;
    @(negedge clk);
    enable = 1'b0; commit_kill[4] = 1'b0;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL kill_issue_ready got %b want 1", ready); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL kill_issue_state got %b want 0", dbg_state); end
    // follow-up op completes normally
    drive_issue(2'd0, 64'h0F, 64'h11, 1'b0, 5'd8);
    wait_strobe(1, cyc, rh);
    n_cmp++; if (cyc !== exp_lat(64'h11, 1'b0)) begin n_bad++; $display("FAIL kill_next_latency got %0d want %0d", cyc, exp_lat(64'h11, 1'b0)); end
    n_cmp++; if (result !== 64'hFF) begin n_bad++; $display("FAIL kill_next_result got %h want ff", result); end
    n_cmp++; if (res_rd !== 5'd8) begin n_bad++; $display("FAIL kill_next_rd got %0d want 8", res_rd); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int cyc;
    int rh;
    drive_issue(2'd0, 64'h3, 64'h8000_0000_0000_0003, 1'b0, 5'd2);
    wait_strobe(1, cyc, rh);
    n_cmp++; if (result !== 64'h8000_0000_0000_0005) begin n_bad++; $display("FAIL b2b_first_result got %h want 8000000000000005", result); end
    // issue the next op in the completion cycle
    control = 2'd0; r1 = 64'h0F; r2 = 64'h8000_0000_0000_0001; rv32 = 1'b0; rd = 5'd3; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_ready got %b want 0", ready); end
    wait_strobe(1, cyc, rh);
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL b2b_latency got %0d want 17", cyc); end
    n_cmp++; if (result !== 64'h8000_0000_0000_000F) begin n_bad++; $display("FAIL b2b_second_result got %h want 800000000000000f", result); end
    n_cmp++; if (res_rd !== 5'd3) begin n_bad++; $display("FAIL b2b_second_rd got %0d want 3", res_rd); end
    @(negedge clk);
  endtask

  task automatic test_busy_enable;
    int cyc;
    int rh;
    drive_issue(2'd0, 64'h3, 64'h8000_0000_0000_0003, 1'b0, 5'd7);
    @(negedge clk);
    @(negedge clk);
    control = 2'd1; r1 = 64'hFFFF_FFFF_FFFF_FFFF; r2 = 64'h1; rd = 5'd9; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_strobe(4, cyc, rh);
    n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL busy_latency got %0d want 17", cyc); end
    n_cmp++; if (result !== 64'h8000_0000_0000_0005) begin n_bad++; $display("FAIL busy_result got %h want 8000000000000005", result); end
    n_cmp++; if (res_rd !== 5'd7) begin n_bad++; $display("FAIL busy_rd got %0d want 7", res_rd); end
    @(negedge clk);
    n_cmp++; if (res_makes_rd !== 1'b0) begin n_bad++; $display("FAIL busy_extra_strobe got %b want 0", res_makes_rd); end
  endtask

  task automatic test_async_reset;
    int seen;
    drive_issue(2'd0, 64'h3, 64'h8000_0000_0000_0000, 1'b0, 5'd10);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready got %b want 1", ready); end
    n_cmp++; if (result !== 64'h0) begin n_bad++; $display("FAIL areset_result got %h want 0", result); end
    n_cmp++; if (res_rd !== 5'd0) begin n_bad++; $display("FAIL areset_rd got %0d want 0", res_rd); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_bad++; $display("FAIL areset_state got %b want 0", dbg_state); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (res_makes_rd !== 1'b0) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL areset_strobe got %0d strobes want 0", seen); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_ops();
    test_kill();
    test_back_to_back();
    test_busy_enable();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
